// File: rtl/ram_port_responder_pkg.sv
// Shared types, limits and helpers for the RAM port responder.
package ram_port_responder_pkg;

  localparam int MAX_READ_LATENCY = 4;

  // Reference request shape for the default port geometry.
  localparam int REQ_ADDR_W = 8;
  localparam int REQ_DATA_W = 32;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } ram_req_t;

  // Increment v by one, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/ram_port_responder_if.sv
// Single-port RAM request/response bundle between a CPU-side initiator and the memory endpoint.
interface ram_port_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ERR_CNT_W  = 8
) ();
  logic                  en;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  oor_err;
  logic [ERR_CNT_W-1:0]  err_count;

  modport MEM (
    input  en, we, addr, wdata,
    output rdata, rvalid, oor_err, err_count
  );

  modport CPU (
    output en, we, addr, wdata,
    input  rdata, rvalid, oor_err, err_count
  );
endinterface

// File: rtl/ram_port_responder_read_pipe.sv
// Read latency stages behind the RAM sampling register. Valid bits are
// always reset so in-flight reads vanish on reset; only the output data
// register is reset as well so rdata reads 0 while in reset. Data stages
// load only when their incoming valid is set, so rdata holds between reads.
module ram_read_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam int NS = READ_LATENCY - 1;

  if (NS == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_pipe
    for (genvar i = 0; i < NS; i++) begin : g_stg
      logic                  v_in;
      logic [DATA_WIDTH-1:0] d_in;
      logic                  v_q;
      logic [DATA_WIDTH-1:0] d_q;

      if (i == 0) begin : g_first
        assign v_in = valid_i;
        assign d_in = data_i;
      end else begin : g_next
        assign v_in = g_stg[i-1].v_q;
        assign d_in = g_stg[i-1].d_q;
      end

      // Shift the valid bit; cleared asynchronously to flush in-flight reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_q <= 1'b0;
        else        v_q <= v_in;
      end

      if (i == NS - 1) begin : g_out
        // Output data register: reset to 0, otherwise loads with each read.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)    d_q <= '0;
          else if (v_in) d_q <= d_in;
        end
      end else begin : g_mid
        // Intermediate data register: no reset, qualified by valid.
        always_ff @(posedge clk) begin
          if (v_in) d_q <= d_in;
        end
      end
    end

    assign valid_o = g_stg[NS-1].v_q;
    assign data_o  = g_stg[NS-1].d_q;
  end
endmodule

// File: rtl/ram_port_responder.sv
// Memory-side endpoint of ram_port_if: storage array, range check,
// saturating out-of-range counter and fixed-latency read return.
module ram_port_responder
  import ram_port_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter int ERR_CNT_W    = 8
) (
  input logic     clk,
  input logic     rst_n,
  ram_port_if.MEM bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("ram_port_responder: READ_LATENCY %0d outside 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("ram_port_responder: DEPTH %0d outside 1..2**ADDR_WIDTH", DEPTH);
  end
  if (ERR_CNT_W < 1 || ERR_CNT_W > 32) begin : g_bad_cnt
    $error("ram_port_responder: ERR_CNT_W %0d outside 1..32", ERR_CNT_W);
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  in_range;
  logic                  rd_req;
  logic                  wr_req;
  logic [IDX_W-1:0]      idx;

  logic                  rd_vld_d, rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_dat_d, rd_dat_q;
  logic                  oor_d, oor_q;
  logic [ERR_CNT_W-1:0]  err_cnt_d, err_cnt_q;

  logic                  pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_dat;

  assign in_range = ({1'b0, bus.addr} < (ADDR_WIDTH+1)'(DEPTH));
  assign rd_req   = bus.en & ~bus.we;
  assign wr_req   = bus.en & bus.we & in_range;
  assign idx      = IDX_W'(bus.addr);

  // Storage write port; no reset, contents are undefined after power-up.
  always_ff @(posedge clk) begin
    if (wr_req) mem_q[idx] <= bus.wdata;
  end

  // Stage-0 read sample, range flag and counter next-state.
  always_comb begin
    rd_vld_d  = rd_req;
    rd_dat_d  = rd_dat_q;
    oor_d     = bus.en & ~in_range;
    err_cnt_d = err_cnt_q;
    if (rd_req) rd_dat_d = in_range ? mem_q[idx] : '0;
    if (oor_d)  err_cnt_d = ERR_CNT_W'(sat_inc(32'(err_cnt_q), ERR_CNT_W));
  end

  // Request-edge registers: sampled read data, oor pulse and error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_dat_q  <= '0;
      oor_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_dat_q  <= rd_dat_d;
      oor_q     <= oor_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  ram_read_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (rd_vld_q),
    .data_i  (rd_dat_q),
    .valid_o (pipe_vld),
    .data_o  (pipe_dat)
  );

  assign bus.rvalid    = pipe_vld;
  assign bus.rdata     = pipe_dat;
  assign bus.oor_err   = oor_q;
  assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_ram_port_responder.sv
// Scoreboarded bench for ram_port_responder across three parameter sets.
module tb_ram_port_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  ram_port_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .ERR_CNT_W(8)) ifa ();
  ram_port_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .ERR_CNT_W(2)) ifb ();
  ram_port_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .ERR_CNT_W(8)) ifc ();

  ram_port_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256),
                       .READ_LATENCY(1), .ERR_CNT_W(8))
    u_dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
  ram_port_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(200),
                       .READ_LATENCY(3), .ERR_CNT_W(2))
    u_dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));
  ram_port_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256),
                       .READ_LATENCY(4), .ERR_CNT_W(8))
    u_dut_c (.clk(clk), .rst_n(rst_c), .bus(ifc));

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  int unsigned cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          e5[5] = '{1, 2, 3, 3, 3};
  logic        seen_c;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cnt);
    end
  endtask

  // Drive one request for the next edge; reads queue their expected return.
  task automatic op(input int inst, input logic w, input logic [7:0] a,
                    input logic [31:0] d, input logic [31:0] exp_rd);
    @(negedge clk);
    case (inst)
      0: begin
        ifa.en = 1'b1; ifa.we = w; ifa.addr = a; ifa.wdata = d;
        if (!w) qa.push_back('{cnt + 1, exp_rd});
      end
      1: begin
        ifb.en = 1'b1; ifb.we = w; ifb.addr = a; ifb.wdata = d;
        if (!w) qb.push_back('{cnt + 3, exp_rd});
      end
      default: begin
        ifc.en = 1'b1; ifc.we = w; ifc.addr = a; ifc.wdata = d;
      end
    endcase
  endtask

  task automatic idle(input int inst);
    @(negedge clk);
    case (inst)
      0:       ifa.en = 1'b0;
      1:       ifb.en = 1'b0;
      default: ifc.en = 1'b0;
    endcase
  endtask

  // Monitor A: every rvalid must match the queue head in data and cycle.
  always @(negedge clk) begin
    if (ifa.rvalid === 1'b1) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_bad++;
        $display("FAIL a_rvalid_unexpected actual rdata=%h required no rvalid (cycle %0d)", ifa.rdata, cnt);
      end else begin
        ea = qa.pop_front();
        if (ifa.rdata !== ea.data || cnt != ea.cyc) begin
          n_bad++;
          $display("FAIL a_read actual=%h@%0d required=%h@%0d", ifa.rdata, cnt, ea.data, ea.cyc);
        end
      end
    end else if (qa.size() != 0 && cnt >= qa[0].cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL a_rvalid_missing actual none@%0d required=%h@%0d", cnt, qa[0].data, qa[0].cyc);
      void'(qa.pop_front());
    end
  end

  // Monitor B: same as A for the latency-3, depth-200 instance.
  always @(negedge clk) begin
    if (ifb.rvalid === 1'b1) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++;
        $display("FAIL b_rvalid_unexpected actual rdata=%h required no rvalid (cycle %0d)", ifb.rdata, cnt);
      end else begin
        eb = qb.pop_front();
        if (ifb.rdata !== eb.data || cnt != eb.cyc) begin
          n_bad++;
          $display("FAIL b_read actual=%h@%0d required=%h@%0d", ifb.rdata, cnt, eb.data, eb.cyc);
        end
      end
    end else if (qb.size() != 0 && cnt >= qb[0].cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL b_rvalid_missing actual none@%0d required=%h@%0d", cnt, qb[0].data, qb[0].cyc);
      void'(qb.pop_front());
    end
  end

  initial begin
    ifa.en = 0; ifa.we = 0; ifa.addr = 0; ifa.wdata = 0;
    ifb.en = 0; ifb.we = 0; ifb.addr = 0; ifb.wdata = 0;
    ifc.en = 0; ifc.we = 0; ifc.addr = 0; ifc.wdata = 0;
    rst_a = 0; rst_b = 0; rst_c = 0;
    repeat (2) @(negedge clk);
    chk("rst_a_rdata", ifa.rdata, 0);
    chk("rst_a_rvalid", 32'(ifa.rvalid), 0);
    chk("rst_a_oor", 32'(ifa.oor_err), 0);
    chk("rst_a_err", 32'(ifa.err_count), 0);
    chk("rst_b_err", 32'(ifb.err_count), 0);
    chk("rst_c_rvalid", 32'(ifc.rvalid), 0);
    @(negedge clk);
    rst_a = 1; rst_b = 1; rst_c = 1;

    // Latency 1: write then read 0x10.
    op(0, 1'b1, 8'h10, 32'hDEADBEEF, 0);
    op(0, 1'b0, 8'h10, 0, 32'hDEADBEEF);
    chk("t1_oor_wr", 32'(ifa.oor_err), 0);
    idle(0);
    chk("t1_oor_rd", 32'(ifa.oor_err), 0);
    chk("t1_err", 32'(ifa.err_count), 0);

    // Write followed immediately by read of the same word; reordered pair.
    op(0, 1'b1, 8'h20, 32'h1234, 0);
    op(0, 1'b0, 8'h20, 0, 32'h1234);
    op(0, 1'b1, 8'h30, 32'h1, 0);
    op(0, 1'b1, 8'h31, 32'h2, 0);
    op(0, 1'b0, 8'h31, 0, 32'h2);
    op(0, 1'b0, 8'h30, 0, 32'h1);
    op(0, 1'b0, 8'hFF, 0, 32'hDEADBEEF & 32'h0); // withdrawn before the next edge
    void'(qa.pop_back());
    ifa.en = 1'b0;
    repeat (3) @(negedge clk);

    // Latency 3: preload then three back-to-back reads.
    op(1, 1'b1, 8'h00, 32'h77, 0);
    op(1, 1'b1, 8'h01, 32'hA, 0);
    op(1, 1'b1, 8'h02, 32'hB, 0);
    op(1, 1'b1, 8'h03, 32'hC, 0);
    op(1, 1'b0, 8'h01, 0, 32'hA);
    op(1, 1'b0, 8'h02, 0, 32'hB);
    op(1, 1'b0, 8'h03, 0, 32'hC);
    idle(1);
    repeat (4) @(negedge clk);

    // Depth 200: out-of-range write and read.
    chk("t4_err0", 32'(ifb.err_count), 0);
    op(1, 1'b1, 8'hF0, 32'h55, 0);
    op(1, 1'b0, 8'hF0, 0, 32'h0);
    chk("t4_oor_wr", 32'(ifb.oor_err), 1);
    chk("t4_err1", 32'(ifb.err_count), 1);
    idle(1);
    chk("t4_oor_rd", 32'(ifb.oor_err), 1);
    chk("t4_err2", 32'(ifb.err_count), 2);
    @(negedge clk);
    chk("t4_oor_clear", 32'(ifb.oor_err), 0);
    chk("t4_err_hold", 32'(ifb.err_count), 2);
    op(1, 1'b0, 8'h00, 0, 32'h77);
    op(1, 1'b0, 8'hC7, 0, 32'h0); // last implemented word, never written: only range matters
    void'(qb.pop_back());
    ifb.en = 1'b0;
    chk("t4_last_in_range", 32'(ifb.oor_err), 0);
    @(negedge clk);
    chk("t4_last_in_range_oor", 32'(ifb.oor_err), 0);
    repeat (5) @(negedge clk);

    // 2-bit counter saturation after a fresh reset.
    rst_b = 0;
    @(negedge clk);
    chk("t5_rst_err", 32'(ifb.err_count), 0);
    chk("t5_rst_rvalid", 32'(ifb.rvalid), 0);
    rst_b = 1;
    for (int i = 0; i < 5; i++) begin
      op(1, 1'b0, 8'(200 + i), 0, 32'h0);
      idle(1);
      chk($sformatf("t5_err_%0d", i), 32'(ifb.err_count), 32'(e5[i]));
      chk($sformatf("t5_oor_%0d", i), 32'(ifb.oor_err), 1);
    end
    repeat (5) @(negedge clk);

    // Latency 4: reset while a read is in flight discards it.
    op(2, 1'b1, 8'h05, 32'h99, 0);
    op(2, 1'b0, 8'h05, 0, 0);
    idle(2);
    @(negedge clk);
    rst_c = 0;
    #1;
    chk("t6_rst_rvalid", 32'(ifc.rvalid), 0);
    chk("t6_rst_rdata", ifc.rdata, 0);
    chk("t6_rst_oor", 32'(ifc.oor_err), 0);
    chk("t6_rst_err", 32'(ifc.err_count), 0);
    @(negedge clk);
    rst_c = 1;
    seen_c = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ifc.rvalid === 1'b1) seen_c = 1'b1;
    end
    chk("t6_no_rvalid", 32'(seen_c), 0);

    repeat (2) @(negedge clk);
    chk("drain_a", 32'(qa.size()), 0);
    chk("drain_b", 32'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
